spi_ram_bridge: RTL and testbench

SPI mode-0 slave that gives an external SPI master read/write access to the on-chip single-port RAM. It is the initiator on the RAM port: it drives `RAM_WE`, `RAM_Addr` and `RAM_Wdata`, and it consumes the RAM's registered read data. All SPI pins are oversampled in the `clk` domain. It sits between the chip's SPI pads and the RAM instance.

---
 rtl/spi_ram_bridge.sv | 195 +++++++++++++++++++
 tb/tb_spi_ram_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI mode-0 slave giving an external master byte-wide
// read/write access to a single-port RAM with registered read data.
// SCLK, CS_n and MOSI are oversampled in the clk domain.
// Optional feature macro: SPI_BRIDGE_AUTOINC_EN (address auto-increment
// per byte; when undefined the frame stays on the command address).
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no frame; waiting for a CS_n fall
// CMD    | shifting in the command byte
// WR     | write frame; one RAM write per completed data byte
// RD_REQ | RAM read issued (RAM_WE=0, RAM_Addr=A)
// RD_CAP | RAM_Rdata valid; loaded into the transmit shifter
// RD     | read frame; shifting MISO out, waiting for next byte end

module spi_ram_bridge #(
    parameter int N = 8,
    parameter int M = 32,
    localparam int AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SCLK,
    input  logic          CS_n,
    input  logic          MOSI,
    output logic          MISO,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_Addr,
    output logic [N-1:0]  RAM_Wdata,
    input  logic [N-1:0]  RAM_Rdata
);

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WR     = 3'd2,
        RD_REQ = 3'd3,
        RD_CAP = 3'd4,
        RD     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sclk_q;
    logic [2:0]    cs_q;
    logic [1:0]    mosi_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [N-2:0]  rx_sh_q, rx_sh_d;
    logic [N-1:0]  tx_sh_q, tx_sh_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          miso_q, miso_d;

    logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic          byte_done;
    logic [N-1:0]  rx_byte;

    function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] a);
        if (!AUTOINC) return a;
        return (a == AW'(M - 1)) ? '0 : a + 1'b1;
    endfunction

    // Synchronisers are reset low so a CS_n already low at reset release
    // never looks like a falling edge; the frame waits for a real high/low.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            cs_q   <= {cs_q[1:0], CS_n};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign rx_byte   = {rx_sh_q, mosi_q[1]};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            addr_q     <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            miso_q     <= miso_d;
        end
    end

    // Next-state and datapath decisions; a CS_n rise overrides everything.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        addr_d     = addr_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        miso_d     = miso_q;

        if (state_q != IDLE && sclk_rise) begin
            rx_sh_d   = rx_byte[N-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                miso_d    = 1'b0;
                if (cs_fall) state_d = CMD;
            end
            CMD: begin
                if (byte_done) begin
                    if (rx_byte[N-1]) begin
                        addr_d  = rx_byte[AW-1:0];
                        state_d = WR;
                    end else begin
                        ram_addr_d = rx_byte[AW-1:0];
                        addr_d     = addr_next(rx_byte[AW-1:0]);
                        state_d    = RD_REQ;
                    end
                end
            end
            WR: begin
                miso_d = 1'b0;
                if (byte_done) begin
                    we_d       = 1'b1;
                    ram_addr_d = addr_q;
                    wdata_d    = rx_byte;
                    addr_d     = addr_next(addr_q);
                end
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                tx_sh_d = RAM_Rdata;
                state_d = RD;
            end
            RD: begin
                if (sclk_fall) begin
                    miso_d  = tx_sh_q[N-1];
                    tx_sh_d = {tx_sh_q[N-2:0], 1'b0};
                end
                if (byte_done) begin
                    ram_addr_d = addr_q;
                    addr_d     = addr_next(addr_q);
                    state_d    = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cs_rise) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            we_d       = 1'b0;
            miso_d     = 1'b0;
            addr_d     = addr_q;
            ram_addr_d = ram_addr_q;
            wdata_d    = wdata_q;
        end
    end

    assign MISO      = miso_q;
    assign RAM_WE    = we_q;
    assign RAM_Addr  = ram_addr_q;
    assign RAM_Wdata = wdata_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed bench for spi_ram_bridge: drives SPI frames, models the RAM,
// logs write pulses and checks MISO bytes against hand-computed values.
// Expectations follow SPI_BRIDGE_AUTOINC_EN when it is defined.

module tb_spi_ram_bridge;

`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       CS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       mem_clr = 1'b1;
    logic       MISO;
    logic       RAM_WE;
    logic [4:0] RAM_Addr;
    logic [7:0] RAM_Wdata;
    logic [7:0] RAM_Rdata;

    logic [7:0] mem [0:31];
    logic [4:0] wa_q [$];
    logic [7:0] wd_q [$];
    bit         miso_hi;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] r;

    spi_ram_bridge #(.N(8), .M(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .CS_n      (CS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .RAM_WE    (RAM_WE),
        .RAM_Addr  (RAM_Addr),
        .RAM_Wdata (RAM_Wdata),
        .RAM_Rdata (RAM_Rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            RAM_Rdata <= 8'h00;
        end else begin
            if (RAM_WE) mem[RAM_Addr] <= RAM_Wdata;
            RAM_Rdata <= mem[RAM_Addr];
        end
    end

    // Log every clk with RAM_WE high and note any MISO activity.
    always @(negedge clk) begin
        if (RAM_WE) begin
            wa_q.push_back(RAM_Addr);
            wd_q.push_back(RAM_Wdata);
        end
        if (MISO) miso_hi = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            MOSI = tx[i];
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            rx[i] = MISO;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_start();
        CS_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (8) @(negedge clk);
        CS_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        miso_hi = 1'b0;
    endtask

    initial begin
        miso_hi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_we", RAM_WE, 0);
        check("rst_addr", RAM_Addr, 0);
        check("rst_wdata", RAM_Wdata, 0);
        rst = 1'b0;
        mem_clr = 1'b0;
        repeat (5) @(negedge clk);

        // Single write 0x85, 0x3C
        clear_log();
        cs_start();
        xfer(8'h85, r);
        xfer(8'h3C, r);
        cs_end();
        check("sw_count", wa_q.size(), 1);
        check("sw_addr", wa_q[0], 5);
        check("sw_data", wd_q[0], 8'h3C);
        check("sw_miso", miso_hi, 0);
        check("sw_idle_we", RAM_WE, 0);
        check("sw_addr_hold", RAM_Addr, 5);

        // Burst write from 30
        clear_log();
        cs_start();
        xfer(8'h9E, r);
        xfer(8'h11, r);
        xfer(8'h22, r);
        xfer(8'h33, r);
        cs_end();
        check("bw_count", wa_q.size(), 3);
        check("bw_a0", wa_q[0], 30);
        check("bw_d0", wd_q[0], 8'h11);
        check("bw_a1", wa_q[1], AI ? 31 : 30);
        check("bw_d1", wd_q[1], 8'h22);
        check("bw_a2", wa_q[2], AI ? 0 : 30);
        check("bw_d2", wd_q[2], 8'h33);

        // Burst read from 30
        clear_log();
        cs_start();
        xfer(8'h1E, r);
        check("br_cmd_miso", r, 8'h00);
        xfer(8'h00, r);
        check("br_b0", r, AI ? 8'h11 : 8'h33);
        xfer(8'h00, r);
        check("br_b1", r, AI ? 8'h22 : 8'h33);
        xfer(8'h00, r);
        check("br_b2", r, 8'h33);
        cs_end();
        check("br_no_write", wa_q.size(), 0);
        check("br_miso_idle", MISO, 0);

        // Abort after 4 bits of a write data byte
        clear_log();
        cs_start();
        xfer(8'h81, r);
        spi_bits(8'hF0, 4, r);
        cs_end();
        check("ab_no_write", wa_q.size(), 0);
        cs_start();
        xfer(8'h82, r);
        xfer(8'h5A, r);
        cs_end();
        check("ab_next_count", wa_q.size(), 1);
        check("ab_next_addr", wa_q[0], 2);
        check("ab_next_data", wd_q[0], 8'h5A);

        // Reset in the middle of a read frame
        clear_log();
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        check("rr_pre_data", r, 8'h5A);
        spi_bits(8'h00, 3, r);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rr_miso", MISO, 0);
        check("rr_we", RAM_WE, 0);
        check("rr_addr", RAM_Addr, 0);
        check("rr_wdata", RAM_Wdata, 0);
        clear_log();
        spi_bits(8'h00, 5, r);
        xfer(8'h80, r);
        xfer(8'hEE, r);
        check("rr_ignored_write", wa_q.size(), 0);
        check("rr_ignored_miso", miso_hi, 0);
        check("rr_ignored_addr", RAM_Addr, 0);
        cs_end();
        cs_start();
        xfer(8'h05, r);
        xfer(8'h00, r);
        check("rr_after_data", r, 8'h3C);
        cs_end();

        // Burst write to 3, then read back 3
        clear_log();
        cs_start();
        xfer(8'h83, r);
        xfer(8'hAA, r);
        xfer(8'hBB, r);
        cs_end();
        check("ni_count", wa_q.size(), 2);
        check("ni_a0", wa_q[0], 3);
        check("ni_d0", wd_q[0], 8'hAA);
        check("ni_a1", wa_q[1], AI ? 4 : 3);
        check("ni_d1", wd_q[1], 8'hBB);
        cs_start();
        xfer(8'h03, r);
        xfer(8'h00, r);
        check("ni_read", r, AI ? 8'hAA : 8'hBB);
        cs_end();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
